// File: rtl/rr_mux_sel_arbiter_if.sv
// Request/grant bundle between the agents and the round-robin arbiter.
// The slave side is the arbiter; the master side is the requesting agents.
interface rr_mux_sel_arbiter_if #(
   parameter int CNT_W = 3
);
   logic [3:0]       req;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic             busy;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output req,
      input  gnt,
      input  sel,
      input  busy,
      input  hold_cnt
   );

   modport slave (
      input  req,
      output gnt,
      output sel,
      output busy,
      output hold_cnt
   );
endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin owner of a shared 4:1 mux select with bounded tenure.
// Every output is a register; req only reaches outputs through a clock edge.
module rr_mux_sel_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_mux_sel_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       gnt_q, gnt_nxt;
   logic [1:0]       sel_q, sel_nxt;
   logic [1:0]       last_q, last_nxt;
   logic [CNT_W-1:0] hold_q, hold_nxt;
   logic             busy_q, busy_nxt;

   logic [1:0]       base;
   logic [1:0]       win;
   logic             others;

   function automatic logic [3:0] onehot(input logic [1:0] i);
      onehot = 4'b0001 << i;
   endfunction

   // First requester after b in rotation; b itself is scanned last.
   function automatic logic [1:0] pick(input logic [3:0] r,
                                       input logic [1:0] b);
      logic [1:0] idx;
      logic       found;
      pick  = b;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = b + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   assign base   = (state == GRANT) ? sel_q : last_q;
   assign win    = pick(bus.req, base);
   assign others = |(bus.req & ~onehot(sel_q));

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      sel_nxt   = sel_q;
      last_nxt  = last_q;
      hold_nxt  = hold_q;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               state_nxt = GRANT;
               gnt_nxt   = onehot(win);
               sel_nxt   = win;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (bus.req[sel_q] && (!others || hold_q < HOLD_TOP)) begin
               if (hold_q < HOLD_TOP)
                  hold_nxt = hold_q + 1'b1;
            end else if (others) begin
               gnt_nxt  = onehot(win);
               sel_nxt  = win;
               last_nxt = sel_q;
               hold_nxt = '0;
            end else begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               last_nxt  = sel_q;
               hold_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = |gnt_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt_q  <= '0;
         sel_q  <= '0;
         last_q <= 2'd3;
         hold_q <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         gnt_q  <= gnt_nxt;
         sel_q  <= sel_nxt;
         last_q <= last_nxt;
         hold_q <= hold_nxt;
         busy_q <= busy_nxt;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = busy_q;
   assign bus.hold_cnt = hold_q;

endmodule
